ddc_core_mc: RTL and testbench
==============================

# ddc_core_mc

Multi-channel, time-multiplexed digital down-converter. Successor to the single-tone DDC core. Each accepted complex input sample is mixed against N_CH independent numerically-controlled local oscillators, one channel per clock. The block produces N_CH tagged complex baseband outputs per input sample for the downstream decimation and readout chain. Phase generation and the sin/cos lookup are internal, so no external DDS compiler is needed.

## Interface
Parameters:
- N_CH, 4: number of LO channels, at least 1.
- DIN_W, 16: signed width of each input I/Q component.
- PH_W, 32: phase accumulator, increment and offset width.
- LUT_AW, 10: sin/cos table address width; the table has 2^LUT_AW entries.
- LO_W, 16: signed LO amplitude width.
- DOUT_W, 32: signed output component width, at most DIN_W+LO_W+1.

Ports:
- clk  in  1  system clock, the only clock.
- rst  in  1  synchronous, active-high reset.
- cfg_we  in  1  write strobe for the channel config.
- cfg_ch  in  max(1,$clog2(N_CH))  channel index to write.
- cfg_pinc  in  PH_W  phase increment per input sample.
- cfg_poff  in  PH_W  phase offset.
- resync  in  1  clears all phase accumulators.
- valid_in  in  1  input sample valid.
- ready_in  out  1  block can accept a sample this cycle.
- data_in  in  2*DIN_W  {Q, I}, two's complement.
- valid_out  out  1  output beat valid.
- ch_out  out  max(1,$clog2(N_CH))  channel tag of the output beat.
- data_out  out  2*DOUT_W  {Q, I}, two's complement.

## Operation
- Per-channel state: acc[k], pinc[k], poff[k]. All are PH_W bits and wrap modulo 2^PH_W.
- Config: when cfg_we is high, pinc[cfg_ch] and poff[cfg_ch] load at the clock edge. If cfg_ch is N_CH or greater, the write is ignored.
- Sequencer has two states, IDLE and RUN.
  - A sample is accepted when valid_in and ready_in are both high. The sample is latched and the sequencer enters RUN with ch=0.
  - In RUN, one channel is processed per cycle, in order 0..N_CH-1.
  - ready_in is high in IDLE and on the cycle that processes channel N_CH-1. This allows back-to-back samples every N_CH cycles.
  - If no sample is accepted after the last channel, the sequencer returns to IDLE.
  - When N_CH=1, ready_in stays high permanently once out of reset.
- Processing channel k:
  - Phase used is phi = acc[k] + poff[k], taken before the accumulator update.
  - The accumulator then updates: acc[k] <= acc[k] + pinc[k].
  - LUT address is phi[PH_W-1 -: LUT_AW].
- LUT contents: cos = round((2^(LO_W-1)-1)·cos(2πa/2^LUT_AW)). sin is the same form with sin.
- Mixing is by exp(-jφ):
  - I_full = I·cos + Q·sin
  - Q_full = Q·cos − I·sin
  - Full width is DIN_W+LO_W+1. The output is the full value arithmetically shifted right by (DIN_W+LO_W+1−DOUT_W). No rounding, no saturation; this cannot overflow.
- resync: all acc[k] become 0 at the edge. If resync coincides with channel k processing, that beat uses the old phase and acc[k] still ends at 0 (resync wins). Channels processed in later cycles see acc=0.
- A config write in the same cycle that channel k is processed: that beat uses the old pinc/poff, and the accumulator update uses the old pinc.

## Timing
- Pipeline, all stages registered:
  - S1: phase add.
  - S2: LUT read.
  - S3: four multiplies.
  - S4: add/sub and shift.
- Channel k of a sample accepted at cycle t appears with valid_out=1 and ch_out=k at cycle t+4+k. Beats for one sample are contiguous and in channel order.
- No output backpressure; valid_out is a one-cycle strobe per beat.
- Reset (rst high at an edge):
  - ready_in=0 while rst is high and 1 the cycle after.
  - valid_out=0, ch_out=0, data_out=0.
  - All acc, pinc and poff are 0; the sequencer is in IDLE.
  - All in-flight pipeline valids are cleared, so nothing emerges after a mid-sample reset.
- valid_in while ready_in=0 is ignored; the sample is not captured.

## Test plan
- Phase zero (N_CH=4, all pinc=poff=0): accept I=1000, Q=0 at cycle t. Expect 4 beats at t+4..t+7 with ch_out=0..3, each I=16383500 and Q=0.
- Quarter-turn offset: poff[2]=0x4000_0000, input I=1000, Q=0. Expect ch 2 I=0 and Q=−16383500; the other channels are unchanged from the phase-zero result.
- Accumulation and wrap:
  - Set pinc[1]=0x4000_0000 and stream 5 samples back-to-back, one every 4 cycles, each I=1000, Q=0.
  - Expect ch 1 I sequence 16383500, 0, −16383500, 0, 16383500.
  - Check ready_in is high only on ch-3 cycles and in IDLE.
- resync mid-stream: after 2 samples of the previous test, pulse resync on the cycle processing ch 1. That beat still uses quarter-turn phase; the next sample's ch 1 uses phase 0 (I=16383500).
- Reset mid-sample: assert rst one cycle after accept. Expect no valid_out for ≥6 cycles, ready_in=1 the cycle after rst drops, and pinc reads back as 0 behaviour (phase 0 outputs).
- Config and throughput edges:
  - A write with cfg_ch=4 has no effect.
  - A write coinciding with a channel's processing cycle applies to the next sample only.
  - With N_CH=1, back-to-back valid_in every cycle yields valid_out every cycle at latency 4.

Source files
------------

// File: rtl/ddc_core_mc.sv
// Time-multiplexed multi-channel DDC: one latched complex sample is mixed against
// N_CH phase-accumulator LOs, one channel per clock, through a 4-stage pipeline.
module ddc_core_mc #(
  parameter int N_CH   = 4,
  parameter int DIN_W  = 16,
  parameter int PH_W   = 32,
  parameter int LUT_AW = 10,
  parameter int LO_W   = 16,
  parameter int DOUT_W = 32,
  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cfg_we,
  input  logic [CH_W-1:0]     cfg_ch,
  input  logic [PH_W-1:0]     cfg_pinc,
  input  logic [PH_W-1:0]     cfg_poff,
  input  logic                resync,
  input  logic                valid_in,
  output logic                ready_in,
  input  logic [2*DIN_W-1:0]  data_in,
  output logic                valid_out,
  output logic [CH_W-1:0]     ch_out,
  output logic [2*DOUT_W-1:0] data_out
);

  localparam int PROD_W = DIN_W + LO_W;
  localparam int FULL_W = DIN_W + LO_W + 1;
  localparam int SH     = FULL_W - DOUT_W;
  localparam int ARR_N  = 1 << CH_W;
  localparam int LUT_N  = 1 << LUT_AW;
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CH - 1);
  localparam logic [CH_W:0]   N_CH_V  = (CH_W + 1)'(N_CH);
  localparam real PI  = 3.14159265358979323846;
  localparam real AMP = $itor((1 << (LO_W - 1)) - 1);

  typedef enum logic {IDLE, RUN} state_t;

  function automatic int roundReal(input real x);
    if (x >= 0.0) return $rtoi(x + 0.5);
    else          return -$rtoi(0.5 - x);
  endfunction

  // Quarter-wave symmetry is not exploited; both tables are full-period constants.
  logic signed [LO_W-1:0] cosTab [LUT_N];
  logic signed [LO_W-1:0] sinTab [LUT_N];

  for (genvar a = 0; a < LUT_N; a++) begin : g_lut
    localparam real ANG = 2.0 * PI * $itor(a) / $itor(LUT_N);
    assign cosTab[a] = LO_W'(roundReal(AMP * $cos(ANG)));
    assign sinTab[a] = LO_W'(roundReal(AMP * $sin(ANG)));
  end

  state_t                   state_q;
  logic [CH_W-1:0]          ch_q;
  logic signed [DIN_W-1:0]  smpI_q, smpQ_q;
  logic                     accept;
  logic                     proc;

  assign ready_in = !rst && (state_q == IDLE || ch_q == LAST_CH);
  assign accept   = valid_in && ready_in;
  assign proc     = (state_q == RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ch_q    <= '0;
      smpI_q  <= '0;
      smpQ_q  <= '0;
    end else if (accept) begin
      state_q <= RUN;
      ch_q    <= '0;
      smpI_q  <= data_in[DIN_W-1:0];
      smpQ_q  <= data_in[2*DIN_W-1:DIN_W];
    end else if (state_q == RUN) begin
      if (ch_q == LAST_CH) state_q <= IDLE;
      else                 ch_q    <= ch_q + CH_W'(1);
    end
  end

  logic [PH_W-1:0] acc_q  [ARR_N];
  logic [PH_W-1:0] pinc_q [ARR_N];
  logic [PH_W-1:0] poff_q [ARR_N];

  // Nonblocking updates mean a same-cycle config write or resync never affects the beat in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ARR_N; i++) begin
        acc_q[i]  <= '0;
        pinc_q[i] <= '0;
        poff_q[i] <= '0;
      end
    end else begin
      if (cfg_we && ({1'b0, cfg_ch} < N_CH_V)) begin
        pinc_q[cfg_ch] <= cfg_pinc;
        poff_q[cfg_ch] <= cfg_poff;
      end
      if (resync) begin
        for (int i = 0; i < ARR_N; i++) acc_q[i] <= '0;
      end else if (proc) begin
        acc_q[ch_q] <= acc_q[ch_q] + pinc_q[ch_q];
      end
    end
  end

  logic [LUT_AW-1:0] lutAddr_d;
  assign lutAddr_d = LUT_AW'((acc_q[ch_q] + poff_q[ch_q]) >> (PH_W - LUT_AW));

  logic                     v1_q, v2_q, v3_q;
  logic [CH_W-1:0]          ch1_q, ch2_q, ch3_q;
  logic [LUT_AW-1:0]        addr1_q;
  logic signed [DIN_W-1:0]  i1_q, q1_q, i2_q, q2_q;
  logic signed [LO_W-1:0]   cos2_q, sin2_q;
  logic signed [PROD_W-1:0] pIc_q, pQs_q, pQc_q, pIs_q;

  // S1 phase add, S2 table read, S3 multiplies, S4 mix by exp(-j*phi) and scale.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q <= 1'b0; v2_q <= 1'b0; v3_q <= 1'b0; valid_out <= 1'b0;
      ch1_q <= '0; ch2_q <= '0; ch3_q <= '0; ch_out <= '0;
      addr1_q <= '0; i1_q <= '0; q1_q <= '0; i2_q <= '0; q2_q <= '0;
      cos2_q <= '0; sin2_q <= '0;
      pIc_q <= '0; pQs_q <= '0; pQc_q <= '0; pIs_q <= '0;
      data_out <= '0;
    end else begin
      v1_q    <= proc;
      ch1_q   <= ch_q;
      addr1_q <= lutAddr_d;
      i1_q    <= smpI_q;
      q1_q    <= smpQ_q;

      v2_q   <= v1_q;
      ch2_q  <= ch1_q;
      cos2_q <= cosTab[addr1_q];
      sin2_q <= sinTab[addr1_q];
      i2_q   <= i1_q;
      q2_q   <= q1_q;

      v3_q  <= v2_q;
      ch3_q <= ch2_q;
      pIc_q <= PROD_W'(i2_q) * PROD_W'(cos2_q);
      pQs_q <= PROD_W'(q2_q) * PROD_W'(sin2_q);
      pQc_q <= PROD_W'(q2_q) * PROD_W'(cos2_q);
      pIs_q <= PROD_W'(i2_q) * PROD_W'(sin2_q);

      valid_out <= v3_q;
      ch_out    <= ch3_q;
      data_out  <= {DOUT_W'((FULL_W'(pQc_q) - FULL_W'(pIs_q)) >>> SH),
                    DOUT_W'((FULL_W'(pIc_q) + FULL_W'(pQs_q)) >>> SH)};
    end
  end

endmodule

// File: tb/tb_ddc_core_mc.sv
// Directed bench for ddc_core_mc: a 4-channel instance plus a 1-channel instance
// driven back-to-back; all expected beats are hand-computed constants.
module tb_ddc_core_mc;

  localparam longint P0 = 64'sd16383500;
  localparam logic [31:0] QT = 32'h4000_0000;
  localparam logic [31:0] HF = 32'h8000_0000;

  typedef struct {
    int     cyc;
    int     ch;
    longint i;
    longint q;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_we, resync, valid_in, ready_in, valid_out;
  logic [1:0]  cfg_ch, ch_out;
  logic [31:0] cfg_pinc, cfg_poff, data_in;
  logic [63:0] data_out;

  logic        bCfgWe, bResync, bValidIn, bReadyIn, bValidOut;
  logic [0:0]  bCfgCh, bChOut;
  logic [31:0] bCfgPinc, bCfgPoff, bDataIn;
  logic [63:0] bDataOut;

  int     checks = 0;
  int     failures = 0;
  int     cyc = 0;
  int     accCyc [8];
  int     accCyc1 [8];
  longint expI [8][4];
  longint expQ [8][4];
  beat_t  beatQ [$];
  beat_t  beatQ1 [$];

  always #5 clk = ~clk;

  ddc_core_mc #(.N_CH(4)) dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_pinc(cfg_pinc),
    .cfg_poff(cfg_poff), .resync(resync), .valid_in(valid_in), .ready_in(ready_in),
    .data_in(data_in), .valid_out(valid_out), .ch_out(ch_out), .data_out(data_out)
  );

  ddc_core_mc #(.N_CH(1)) dut1 (
    .clk(clk), .rst(rst), .cfg_we(bCfgWe), .cfg_ch(bCfgCh), .cfg_pinc(bCfgPinc),
    .cfg_poff(bCfgPoff), .resync(bResync), .valid_in(bValidIn), .ready_in(bReadyIn),
    .data_in(bDataIn), .valid_out(bValidOut), .ch_out(bChOut), .data_out(bDataOut)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid_out)
      beatQ.push_back('{cyc, int'(ch_out), longint'($signed(data_out[31:0])),
                        longint'($signed(data_out[63:32]))});
    if (bValidOut)
      beatQ1.push_back('{cyc, int'(bChOut), longint'($signed(bDataOut[31:0])),
                         longint'($signed(bDataOut[63:32]))});
  end

  task automatic checkOutput(input string tag, input logic signed [63:0] obs,
                             input logic signed [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic cfgWrite(input logic [1:0] ch, input logic [31:0] pinc, input logic [31:0] poff);
    cfg_we = 1'b1; cfg_ch = ch; cfg_pinc = pinc; cfg_poff = poff;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic pulseResync();
    resync = 1'b1;
    tick();
    resync = 1'b0;
  endtask

  task automatic fillExp(input int n);
    for (int s = 0; s < n; s++)
      for (int k = 0; k < 4; k++) begin
        expI[s][k] = P0;
        expQ[s][k] = 0;
      end
  endtask

  // evKind 1 pulses resync, 2 issues a config write, on sample evSample's channel evCh cycle.
  task automatic applyStimulus(input int n, input int evSample, input int evCh, input int evKind,
                               input logic [1:0] evCfgCh, input logic [31:0] evPinc,
                               input logic [31:0] evPoff);
    beatQ.delete();
    valid_in = 1'b1;
    data_in  = {16'h0000, 16'd1000};
    for (int s = 0; s < n; s++) begin
      checkOutput($sformatf("readyAccept_s%0d", s), 64'(ready_in), 64'(1));
      accCyc[s] = cyc + 1;
      for (int k = 0; k < 4; k++) begin
        tick();
        if (s == evSample && k == evCh) begin
          resync = (evKind == 1);
          if (evKind == 2) begin
            cfg_we = 1'b1; cfg_ch = evCfgCh; cfg_pinc = evPinc; cfg_poff = evPoff;
          end
        end else begin
          resync = 1'b0;
          cfg_we = 1'b0;
        end
        if (k < 3) checkOutput($sformatf("readyBusy_s%0d_c%0d", s, k), 64'(ready_in), 64'(0));
        if (k == 3 && s == n - 1) valid_in = 1'b0;
      end
    end
    checkOutput("readyLastCh", 64'(ready_in), 64'(1));
    tick();
    resync = 1'b0;
    cfg_we = 1'b0;
    checkOutput("readyIdle", 64'(ready_in), 64'(1));
    repeat (8) tick();
  endtask

  task automatic verifyBeats(input int n, input string name);
    beat_t b;
    checkOutput({name, "_count"}, 64'(beatQ.size()), 64'(n * 4));
    for (int s = 0; s < n; s++)
      for (int k = 0; k < 4; k++)
        if (beatQ.size() > 0) begin
          b = beatQ.pop_front();
          checkOutput($sformatf("%s_s%0d_c%0d_cyc", name, s, k), 64'(b.cyc), 64'(accCyc[s] + 4 + k));
          checkOutput($sformatf("%s_s%0d_c%0d_ch", name, s, k), 64'(b.ch), 64'(k));
          checkOutput($sformatf("%s_s%0d_c%0d_I", name, s, k), b.i, expI[s][k]);
          checkOutput($sformatf("%s_s%0d_c%0d_Q", name, s, k), b.q, expQ[s][k]);
        end
  endtask

  function automatic logic [31:0] pack(input int iv, input int qv);
    return {qv[15:0], iv[15:0]};
  endfunction

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int     sI [6];
    int     sQ [6];
    longint eI [6];
    longint eQ [6];
    beat_t  b;

    rst = 1'b1;
    cfg_we = 0; cfg_ch = 0; cfg_pinc = 0; cfg_poff = 0; resync = 0; valid_in = 0; data_in = 0;
    bCfgWe = 0; bCfgCh = 0; bCfgPinc = 0; bCfgPoff = 0; bResync = 0; bValidIn = 0; bDataIn = 0;
    repeat (3) tick();
    checkOutput("rstReady", 64'(ready_in), 64'(0));
    checkOutput("rstValidOut", 64'(valid_out), 64'(0));
    checkOutput("rstChOut", 64'(ch_out), 64'(0));
    checkOutput("rstDataOut", data_out, 64'(0));
    checkOutput("rstReady1", 64'(bReadyIn), 64'(0));
    rst = 1'b0;
    tick();
    checkOutput("postRstReady", 64'(ready_in), 64'(1));
    checkOutput("postRstReady1", 64'(bReadyIn), 64'(1));

    $display("[TB] phase zero");
    fillExp(1);
    applyStimulus(1, -1, 0, 0, 2'd0, 32'd0, 32'd0);
    verifyBeats(1, "phaseZero");

    $display("[TB] quarter-turn offset on ch2");
    cfgWrite(2'd2, 32'd0, QT);
    fillExp(1);
    expI[0][2] = 0; expQ[0][2] = -P0;
    applyStimulus(1, -1, 0, 0, 2'd0, 32'd0, 32'd0);
    verifyBeats(1, "quarterOff");
    cfgWrite(2'd2, 32'd0, 32'd0);

    $display("[TB] accumulation and wrap on ch1");
    cfgWrite(2'd1, QT, 32'd0);
    fillExp(5);
    expI[1][1] = 0;   expQ[1][1] = -P0;
    expI[2][1] = -P0; expQ[2][1] = 0;
    expI[3][1] = 0;   expQ[3][1] = P0;
    applyStimulus(5, -1, 0, 0, 2'd0, 32'd0, 32'd0);
    verifyBeats(5, "accWrap");

    $display("[TB] resync mid-stream");
    pulseResync();
    fillExp(3);
    expI[1][1] = 0; expQ[1][1] = -P0;
    applyStimulus(3, 1, 1, 1, 2'd0, 32'd0, 32'd0);
    verifyBeats(3, "resync");

    $display("[TB] config write during processing");
    pulseResync();
    cfgWrite(2'd1, 32'd0, 32'd0);
    fillExp(2);
    expI[1][2] = -P0; expQ[1][2] = 0;
    applyStimulus(2, 0, 2, 2, 2'd2, QT, HF);
    verifyBeats(2, "cfgCollide");

    $display("[TB] reset mid-sample");
    beatQ.delete();
    valid_in = 1'b1;
    data_in  = {16'h0000, 16'd1000};
    checkOutput("rstMidAccept", 64'(ready_in), 64'(1));
    tick();
    valid_in = 1'b0;
    rst = 1'b1;
    tick();
    checkOutput("rstMidReadyLow", 64'(ready_in), 64'(0));
    rst = 1'b0;
    tick();
    checkOutput("rstMidReadyHigh", 64'(ready_in), 64'(1));
    repeat (8) tick();
    checkOutput("rstMidNoBeats", 64'(beatQ.size()), 64'(0));
    fillExp(1);
    applyStimulus(1, -1, 0, 0, 2'd0, 32'd0, 32'd0);
    verifyBeats(1, "afterRst");

    $display("[TB] single-channel back-to-back");
    bCfgWe = 1'b1; bCfgCh = 1'b1; bCfgPinc = QT; bCfgPoff = QT;
    tick();
    bCfgWe = 1'b0;
    sI = '{1000, -1000, 3, -3, 2, -32768};
    sQ = '{0, 0, 5, -1, 0, 32767};
    eI = '{P0, -P0, 64'sd49150, -64'sd49151, 64'sd32767, -64'sd536854528};
    eQ = '{0, 0, 64'sd81917, -64'sd16384, 0, 64'sd536838144};
    beatQ1.delete();
    for (int s = 0; s < 6; s++) begin
      bValidIn = 1'b1;
      bDataIn  = pack(sI[s], sQ[s]);
      checkOutput($sformatf("nch1Ready_s%0d", s), 64'(bReadyIn), 64'(1));
      accCyc1[s] = cyc + 1;
      tick();
    end
    bValidIn = 1'b0;
    repeat (8) tick();
    checkOutput("nch1_count", 64'(beatQ1.size()), 64'(6));
    for (int s = 0; s < 6; s++)
      if (beatQ1.size() > 0) begin
        b = beatQ1.pop_front();
        checkOutput($sformatf("nch1_s%0d_cyc", s), 64'(b.cyc), 64'(accCyc1[s] + 4));
        checkOutput($sformatf("nch1_s%0d_ch", s), 64'(b.ch), 64'(0));
        checkOutput($sformatf("nch1_s%0d_I", s), b.i, eI[s]);
        checkOutput($sformatf("nch1_s%0d_Q", s), b.q, eQ[s]);
      end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
